// File: rtl/bbpd_pkg.sv
// Shared helpers for the bang-bang phase detector vote accumulator:
// width derivation, saturating add and per-UI vote encoding.
package bbpd_pkg;

    localparam logic [1:0] VOTE_NONE = 2'd0;
    localparam logic [1:0] VOTE_UP   = 2'd1;
    localparam logic [1:0] VOTE_DN   = 2'd2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    // Bits needed to hold a popcount of 0..n_ui votes.
    function automatic int vote_w(input int n_ui);
        return clog2(n_ui + 1);
    endfunction

    function automatic int sat_add(input int a, input int b, input int lim);
        int s;
        s = a + b;
        if (s > lim)       return lim;
        else if (s < -lim) return -lim;
        else               return s;
    endfunction

endpackage

// File: rtl/bbpd_vote_count.sv
// Combinational Alexander early/late vote per UI plus up/down popcounts.
module bbpd_vote_count
    import bbpd_pkg::*;
#(
    parameter int N_UI   = 4,
    parameter int VOTE_W = 3
) (
    input  logic [N_UI-1:0]   din_data,
    input  logic [N_UI-1:0]   din_edge,
    input  logic              prev_bit,
    input  logic              have_prev,
    output logic [VOTE_W-1:0] up_cnt,
    output logic [VOTE_W-1:0] dn_cnt
);

    logic [N_UI-1:0]       dprev;
    logic [N_UI-1:0]       en;
    logic [N_UI-1:0][1:0]  vote;

    // UI 0 compares against the last bit of the previous word.
    assign dprev = {din_data[N_UI-2:0], prev_bit};
    assign en    = {{(N_UI-1){1'b1}}, have_prev};

    for (genvar k = 0; k < N_UI; k++) begin : g_ui
        assign vote[k] = (!en[k] || din_data[k] == dprev[k]) ? VOTE_NONE :
                         (din_edge[k] == din_data[k])        ? VOTE_UP   : VOTE_DN;
    end

    always_comb begin
        up_cnt = '0;
        dn_cnt = '0;
        for (int k = 0; k < N_UI; k++) begin
            up_cnt = up_cnt + VOTE_W'(vote[k] == VOTE_UP);
            dn_cnt = dn_cnt + VOTE_W'(vote[k] == VOTE_DN);
        end
    end

endmodule

// File: rtl/bbpd_vote_acc.sv
// Multi-UI bang-bang phase detector: vote, integrate, pulse up/down at THRESH.
// Define BBPD_STATS_EN to add trans_cnt/slip_cnt statistics outputs.
module bbpd_vote_acc
    import bbpd_pkg::*;
#(
    parameter int  N_UI   = 4,
    parameter int  ACC_W  = 8,
    parameter int  THRESH = 16,
    localparam int VOTE_W = vote_w(N_UI)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [N_UI-1:0]         din_data,
    input  logic [N_UI-1:0]         din_edge,
    output logic                    up,
    output logic                    down,
    output logic signed [VOTE_W:0]  vote_net,
    output logic signed [ACC_W-1:0] acc_out
`ifdef BBPD_STATS_EN
    ,
    output logic [15:0]             trans_cnt,
    output logic [15:0]             slip_cnt
`endif
);

    localparam int LIM = 2**(ACC_W-1) - 1;

    logic [VOTE_W-1:0]       up_cnt, dn_cnt;
    logic                    prev_bit, have_prev;
    logic signed [ACC_W-1:0] acc;
    int                      sum;
    logic                    hit_up, hit_dn;

    bbpd_vote_count #(.N_UI(N_UI), .VOTE_W(VOTE_W)) u_vote (
        .din_data  (din_data),
        .din_edge  (din_edge),
        .prev_bit  (prev_bit),
        .have_prev (have_prev),
        .up_cnt    (up_cnt),
        .dn_cnt    (dn_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vote_net  <= '0;
            prev_bit  <= 1'b0;
            have_prev <= 1'b0;
        end else if (in_valid) begin
            vote_net  <= $signed({1'b0, up_cnt}) - $signed({1'b0, dn_cnt});
            prev_bit  <= din_data[N_UI-1];
            have_prev <= 1'b1;
        end else begin
            vote_net  <= '0;
        end
    end

    always_comb begin
        sum    = sat_add(int'(acc), int'(vote_net), LIM);
        hit_up = (sum >= THRESH);
        hit_dn = !hit_up && (sum <= -THRESH);
    end

    // Crossing the threshold clears the accumulator; excess is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            up   <= 1'b0;
            down <= 1'b0;
        end else begin
            up   <= hit_up;
            down <= hit_dn;
            acc  <= (hit_up || hit_dn) ? '0 : ACC_W'(sum);
        end
    end

    assign acc_out = acc;

`ifdef BBPD_STATS_EN
    logic [VOTE_W-1:0] trans_s1;
    logic [16:0]       tsum, ssum;

    assign tsum = {1'b0, trans_cnt} + 17'(trans_s1);
    assign ssum = {1'b0, slip_cnt} + 17'(hit_up || hit_dn);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trans_s1  <= '0;
            trans_cnt <= '0;
            slip_cnt  <= '0;
        end else begin
            trans_s1  <= in_valid ? up_cnt + dn_cnt : '0;
            trans_cnt <= tsum[16] ? 16'hFFFF : tsum[15:0];
            slip_cnt  <= ssum[16] ? 16'hFFFF : ssum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_bbpd_vote_acc.sv
// Self-checking bench for bbpd_vote_acc: directed table, corner sequences,
// and randomized words against a UI-level reference model.
module tb_bbpd_vote_acc;

    localparam int N_UI   = 4;
    localparam int ACC_W  = 8;
    localparam int THRESH = 4;
    localparam int LIM    = 127;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [3:0]        din_data, din_edge;
    logic              up, down;
    logic signed [3:0] vote_net;
    logic signed [7:0] acc_out;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_vnet, m_acc, m_up, m_dn;
    bit m_prev, m_have;

    bbpd_vote_acc #(.N_UI(N_UI), .ACC_W(ACC_W), .THRESH(THRESH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .din_data (din_data),
        .din_edge (din_edge),
        .up       (up),
        .down     (down),
        .vote_net (vote_net),
        .acc_out  (acc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rst_first;
        bit         v;
        logic [3:0] d;
        logic [3:0] e;
        int         vnet;
        int         up;
        int         dn;
        int         acc;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_vnet = 0; m_acc = 0; m_up = 0; m_dn = 0; m_prev = 0; m_have = 0;
    endtask

    // One rising edge of the word clock in the reference model.
    task automatic model_edge();
        int s, n;
        bit dp;
        s = m_acc + m_vnet;
        if (s > LIM) s = LIM;
        if (s < -LIM) s = -LIM;
        m_up = 0; m_dn = 0;
        if (s >= THRESH)       begin m_up = 1; m_acc = 0; end
        else if (s <= -THRESH) begin m_dn = 1; m_acc = 0; end
        else                   m_acc = s;
        if (in_valid) begin
            n = 0;
            for (int k = 0; k < N_UI; k++) begin
                if (k == 0) begin
                    if (!m_have) continue;
                    dp = m_prev;
                end else begin
                    dp = din_data[k-1];
                end
                if (din_data[k] != dp) n += (din_edge[k] == din_data[k]) ? 1 : -1;
            end
            m_vnet = n;
            m_prev = din_data[N_UI-1];
            m_have = 1;
        end else begin
            m_vnet = 0;
        end
    endtask

    task automatic check_model();
        chk("model_vote_net", int'(vote_net), m_vnet);
        chk("model_up", int'(up), m_up);
        chk("model_down", int'(down), m_dn);
        chk("model_acc", int'(acc_out), m_acc);
        chk("up_down_exclusive", int'(up & down), 0);
    endtask

    task automatic step(input bit v, input logic [3:0] d, input logic [3:0] e);
        in_valid = v; din_data = d; din_edge = e;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'($urandom); din_data = 4'($urandom); din_edge = 4'($urandom);
            @(posedge clk);
            #1;
            chk("rst_up", int'(up), 0);
            chk("rst_down", int'(down), 0);
            chk("rst_acc", int'(acc_out), 0);
            chk("rst_vote_net", int'(vote_net), 0);
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; din_data = '0; din_edge = '0;

        // early (all up) then late (all down) from a clean reset
        tbl[0] = '{1, 1, 4'b1010, 4'b1010,  3, 0, 0,  0};
        tbl[1] = '{0, 1, 4'b1010, 4'b1010,  4, 0, 0,  3};
        tbl[2] = '{0, 1, 4'b1010, 4'b1010,  4, 1, 0,  0};
        tbl[3] = '{0, 1, 4'b1010, 4'b1010,  4, 1, 0,  0};
        tbl[4] = '{0, 1, 4'b1010, 4'b1010,  4, 1, 0,  0};
        tbl[5] = '{1, 1, 4'b1010, 4'b0101, -3, 0, 0,  0};
        tbl[6] = '{0, 1, 4'b1010, 4'b0101, -4, 0, 0, -3};
        tbl[7] = '{0, 1, 4'b1010, 4'b0101, -4, 0, 1,  0};
        tbl[8] = '{0, 1, 4'b1010, 4'b0101, -4, 0, 1,  0};
        tbl[9] = '{0, 1, 4'b1010, 4'b0101, -4, 0, 1,  0};

        do_reset();

        // no transitions
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 4'b0000, 4'($urandom));
            chk("idle_vote_net", int'(vote_net), 0);
            chk("idle_up", int'(up), 0);
            chk("idle_down", int'(down), 0);
        end

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].rst_first) do_reset();
            step(tbl[i].v, tbl[i].d, tbl[i].e);
            chk($sformatf("tbl%0d_vote_net", i), int'(vote_net), tbl[i].vnet);
            chk($sformatf("tbl%0d_up", i), int'(up), tbl[i].up);
            chk($sformatf("tbl%0d_down", i), int'(down), tbl[i].dn);
            chk($sformatf("tbl%0d_acc", i), int'(acc_out), tbl[i].acc);
        end

        // balanced: 2 up / 2 down words alternating with zero-vote words
        do_reset();
        step(1'b1, 4'b1111, 4'($urandom));
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 4'b1010, 4'b0110);
            chk("bal_vote_net", int'(vote_net), 0);
            chk("bal_acc", int'(acc_out), 0);
            step(1'b1, 4'b1111, 4'($urandom));
            chk("bal_acc", int'(acc_out), 0);
            chk("bal_up", int'(up), 0);
            chk("bal_down", int'(down), 0);
        end

        // reset mid-run with acc at 3, then UI 0 must not vote
        do_reset();
        step(1'b1, 4'b1010, 4'b1010);
        step(1'b0, 4'b0000, 4'b0000);
        chk("mid_acc_before", int'(acc_out), 3);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("mid_acc_async", int'(acc_out), 0);
        chk("mid_vote_net_async", int'(vote_net), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(1'b1, 4'b1010, 4'b1010);
        chk("mid_first_word_vote_net", int'(vote_net), 3);

        // randomized words
        do_reset();
        for (int i = 0; i < 400; i++)
            step(($urandom % 4) != 0, 4'($urandom), 4'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
